// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fnd_pkg
// Purpose  : Shared constants for the 4-digit FND scan display: active-low
//            segment codes (bit order {dp,g,f,e,d,c,b,a}, dp always off) and
//            the digit-select width/type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fnd_pkg;

  localparam int DIGIT_SEL_W = 2;
  localparam int NUM_DIGITS  = 4;
  localparam int VALUE_W     = 14;
  localparam int MAX_VALUE   = 9999;

  typedef logic [DIGIT_SEL_W-1:0] digit_sel_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage : fnd_pkg
`default_nettype wire

// File: rtl/bcd_to_fnd.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_fnd
// Purpose  : Purely combinational BCD digit to active-low 7-segment encoder.
//            Dash takes priority over blank; any non-decimal digit code is
//            shown blank so a corrupted value never lights a bogus pattern.
// Ports    : digit [3:0] in  - BCD digit 0..9
//            blank       in  - force all segments off
//            dash        in  - show the centre bar only (out-of-range marker)
//            seg   [7:0] out - active-low segments {dp,g,f,e,d,c,b,a}
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_fnd
  import fnd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule : bcd_to_fnd
`default_nettype wire

// File: rtl/fnd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : fnd_scan_controller
// Purpose  : Time-multiplexed driver for a 4-digit common-anode FND. Latches
//            the input value once per scan frame (so digits never tear),
//            splits it into decimal digits, optionally blanks leading zeros
//            and shows dashes on every digit for values above 9999.
// Ports    : clk              in  - system clock, rising edge
//            reset            in  - synchronous, active-high
//            count_data [13:0] in - value to display, 0..9999 valid
//            fnd_data   [7:0] out - segments, active-low {dp,g,f,e,d,c,b,a}
//            fnd_com    [3:0] out - digit enables, active-low, bit0 = ones
// Revision : 1.0 - initial release
// ============================================================================
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int LZB      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [VALUE_W-1:0]   count_data,
  output logic [7:0]           fnd_data,
  output logic [NUM_DIGITS-1:0] fnd_com
);

  localparam int DIV   = CLK_FREQ / SCAN_HZ;
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  digit_sel_t         digit_sel;
  logic [VALUE_W-1:0] latched;

  // --------------------------------------------------------------------------
  // Divider: one-cycle tick every DIV clocks.
  // --------------------------------------------------------------------------
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Digit scan and frame latch. The latch happens on the tick that leaves
  // the thousands digit, so a new value always starts at the ones digit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_sel <= '0;
      latched   <= '0;
    end else if (tick) begin
      digit_sel <= digit_sel + 1'b1;
      if (digit_sel == digit_sel_t'(NUM_DIGITS - 1)) begin
        latched <= count_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Decimal split of the latched value. Only meaningful for <= 9999; larger
  // values are overridden by the dash path, so truncation there is harmless.
  // --------------------------------------------------------------------------
  logic [3:0] digits [NUM_DIGITS];
  logic       out_of_range;
  logic [NUM_DIGITS-1:0] lead_zero;

  always_comb begin
    digits[0] = 4'(latched % 14'd10);
    digits[1] = 4'((latched / 14'd10) % 14'd10);
    digits[2] = 4'((latched / 14'd100) % 14'd10);
    digits[3] = 4'(latched / 14'd1000);
  end

  assign out_of_range = (latched > VALUE_W'(MAX_VALUE));

  // A digit is a leading zero when it and every higher digit are zero.
  // The ones digit is never blanked so that zero still shows "0".
  assign lead_zero[3] = (digits[3] == 4'd0);
  assign lead_zero[2] = lead_zero[3] && (digits[2] == 4'd0);
  assign lead_zero[1] = lead_zero[2] && (digits[1] == 4'd0);
  assign lead_zero[0] = 1'b0;

  logic [3:0] sel_digit;
  logic       sel_blank;
  logic [7:0] sel_seg;

  always_comb begin
    sel_digit = digits[digit_sel];
    sel_blank = (LZB != 0) && lead_zero[digit_sel];
  end

  bcd_to_fnd u_bcd_to_fnd (
    .digit (sel_digit),
    .blank (sel_blank),
    .dash  (out_of_range),
    .seg   (sel_seg)
  );

  // --------------------------------------------------------------------------
  // Registered pins: one cycle behind digit_sel/latched.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fnd_com  <= '1;
      fnd_data <= SEG_BLANK;
    end else begin
      fnd_com  <= ~(NUM_DIGITS'(1) << digit_sel);
      fnd_data <= sel_seg;
    end
  end

endmodule : fnd_scan_controller
`default_nettype wire

// File: tb/tb_fnd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_fnd_scan_controller
// Purpose  : Self-checking bench for fnd_scan_controller with DIV=4. Two DUTs
//            (blanking on / off) share stimulus; a cycle-indexed reference
//            model predicts the pins every clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fnd_scan_controller;

  localparam int CLK_FREQ = 40;
  localparam int SCAN_HZ  = 10;
  localparam int DIV      = CLK_FREQ / SCAN_HZ;
  localparam int FRAME    = 4 * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] count_data = '0;
  logic [7:0]  fnd_data_lzb, fnd_data_nolzb;
  logic [3:0]  fnd_com_lzb, fnd_com_nolzb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fnd_scan_controller #(.CLK_FREQ(CLK_FREQ), .SCAN_HZ(SCAN_HZ), .LZB(1)) dut_lzb (
    .clk        (clk),
    .reset      (reset),
    .count_data (count_data),
    .fnd_data   (fnd_data_lzb),
    .fnd_com    (fnd_com_lzb)
  );

  fnd_scan_controller #(.CLK_FREQ(CLK_FREQ), .SCAN_HZ(SCAN_HZ), .LZB(0)) dut_nolzb (
    .clk        (clk),
    .reset      (reset),
    .count_data (count_data),
    .fnd_data   (fnd_data_nolzb),
    .fnd_com    (fnd_com_nolzb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: segment code for decimal digit d of value v.
  function automatic logic [7:0] seg_of(input int dig);
    case (dig)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int v, input int d, input bit lzb);
    int p;
    p = (d == 0) ? 1 : (d == 1) ? 10 : (d == 2) ? 100 : 1000;
    if (v > 9999) return 8'hBF;
    if (lzb && d > 0 && v < p) return 8'hFF;
    return seg_of((v / p) % 10);
  endfunction

  // Model state: cycles since reset release and the value on display.
  int cyc   = 0;
  int shown = 0;

  always @(posedge clk) begin
    int d;
    logic [3:0] ecom;
    #1;
    if (reset) begin
      cyc   = 0;
      shown = 0;
      check("rst_com_lzb",    32'(fnd_com_lzb),    32'hF);
      check("rst_data_lzb",   32'(fnd_data_lzb),   32'h FF);
      check("rst_com_nolzb",  32'(fnd_com_nolzb),  32'h F);
      check("rst_data_nolzb", 32'(fnd_data_nolzb), 32'h FF);
    end else begin
      cyc++;
      d    = ((cyc - 1) / DIV) % 4;
      ecom = ~(4'b0001 << d);
      check($sformatf("com_lzb c%0d", cyc),   32'(fnd_com_lzb),   32'(ecom));
      check($sformatf("com_nolzb c%0d", cyc), 32'(fnd_com_nolzb), 32'(ecom));
      check($sformatf("data_lzb c%0d v%0d d%0d", cyc, shown, d),
            32'(fnd_data_lzb),   32'(exp_seg(shown, d, 1'b1)));
      check($sformatf("data_nolzb c%0d v%0d d%0d", cyc, shown, d),
            32'(fnd_data_nolzb), 32'(exp_seg(shown, d, 1'b0)));
      // The edge closing each frame captures the input for the next frame.
      if (cyc % FRAME == 0) shown = int'(count_data);
    end
  end

  // Advance to the point where exactly 'n' post-release edges have occurred.
  int drv_cyc = 0;
  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      if (!reset) drv_cyc++;
    end
  endtask

  task automatic wait_until(input int n);
    while (drv_cyc < n) step(1);
  endtask

  task automatic do_reset(input int k);
    reset = 1'b1;
    repeat (k) @(negedge clk);
    reset   = 1'b0;
    drv_cyc = 0;
  endtask

  initial begin
    @(negedge clk);
    count_data = 14'd0;
    do_reset(3);

    wait_until(8);   count_data = 14'd1234;  // shown in frame 1
    wait_until(24);  count_data = 14'd7;     // frame 2
    wait_until(40);  count_data = 14'd9999;  // frame 3
    wait_until(54);  count_data = 14'd42;    // mid-frame, digit 1: frame 4
    wait_until(70);  count_data = 14'd12000; // frame 5, dashes
    wait_until(90);  count_data = 14'd5678;  // frame 6
    wait_until(106);                         // digit 2 of the 5678 frame
    do_reset(2);
    count_data = 14'd0;
    wait_until(3);   count_data = 14'd5;
    wait_until(40);

    // Randomized phase: mix of small values (blanking) and full range.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) != 0)
        count_data = 14'($urandom_range(0, 120));
      else
        count_data = 14'($urandom_range(0, 16383));
      step($urandom_range(1, 24));
      if ($urandom_range(0, 14) == 0) begin
        do_reset($urandom_range(1, 3));
      end
    end
    step(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fnd_scan_controller
`default_nettype wire
